cam_capture_rgb111: RTL
=======================

// Module: cam_capture_rgb111
// PURPOSE
//   Capture stage between the OV7670 camera bus and the dual-port frame buffer.
//   Pairs camera bytes (RGB444, two bytes per pixel) into pixels and reduces each to RGB111.
//   Issues one write per pixel into the 160x120 buffer, with linear address = row*CAM_SCREEN_X + col.
//   Also flags frame completion and malformed lines.
// PARAMETERS
//   CAM_SCREEN_X  160  pixels per line stored
//   CAM_SCREEN_Y  120  lines per frame stored
//   AW            15   buffer address width, ceil(log2(X*Y))
//   DW            3    stored pixel width, RGB111 as {R,G,B}
// PORTS
//   clk          in   1   camera pixel clock (pclk); the only clock
//   rst          in   1   asynchronous, active-high reset
//   data         in   8   camera data bus
//   vsync        in   1   camera vsync; high = vertical blanking
//   href         in   1   camera href; high = valid bytes on data
//   en           in   1   capture enable; sampled only at frame start
//   mem_px_addr  out  AW  write address to buffer
//   mem_px_data  out  DW  write data {R,G,B}
//   px_wr        out  1   write strobe, one clk per pixel
//   frame_done   out  1   1-clk pulse: complete frame stored
//   line_err     out  1   1-clk pulse: odd byte count or overlong line
// BEHAVIOUR
// - Reset values: all outputs 0, state S_VBLANK, counters 0.
// - All outputs are registered. Inputs are sampled on clk rising edge; no synchronisers, because clk is pclk.
// - Byte format:
//   - byte0 = {xxxx,R[3:0]}; byte1 = {G[3:0],B[3:0]}.
//   - Pixel = {byte0[3], byte1[7], byte1[3]}.
// - State S_VBLANK:
//   - Clear col, row and the frame-active flag.
//   - On vsync falling: if en=1, go to S_LINE_IDLE; else go to S_SKIP.
// - State S_SKIP:
//   - Ignore everything until vsync rises, then go to S_VBLANK. No writes, no pulses.
// - State S_LINE_IDLE:
//   - href=1 → latch data as byte0, go to S_BYTE1.
// - State S_BYTE1:
//   - href=1 → byte1 = data. Issue the write and go to S_BYTE0.
//   - href=0 → line ended on an odd byte. Pulse line_err, advance the row, go to S_LINE_IDLE.
// - State S_BYTE0:
//   - href=1 → latch byte0, go to S_BYTE1.
//   - href=0 → end of line: col=0, row+1, go to S_LINE_IDLE.
// - Write timing:
//   - Byte1 sampled at edge N → at edge N: px_wr=1, mem_px_addr=row*X+col, mem_px_data=pixel.
//   - Latency is 1 clk from the byte1 sample. px_wr is high for exactly one clk; addr and data hold until the next write.
// - Column and row limits:
//   - col increments after each write.
//   - When col=X, further pixels on that line are not written; pulse line_err once for that line.
//   - Rows with row >= Y are never written; no error is raised for them.
// - Address arithmetic:
//   - row*X is kept as an incrementally accumulated base register (+X per line). No multiplier.
//   - Width is AW; maximum address is X*Y-1 = 19199.
// - vsync rising in any capturing state:
//   - Abort any partial pixel (no write) and go to S_VBLANK.
//   - Pulse frame_done only if row >= Y and the frame was captured with en=1.
// - Simultaneous events: vsync rising has priority over href on the same edge.
// - en changing mid-frame has no effect until the next vsync fall.
// - rst is allowed mid-frame: asynchronous return to reset values. Capture resumes at the next full vsync cycle.
// STRUCTURE
// - Shared package cam_pkg holds:
//   - state encoding (S_VBLANK, S_SKIP, S_LINE_IDLE, S_BYTE0, S_BYTE1)
//   - CAM_SCREEN_X/Y defaults
//   - RGB444→RGB111 bit positions
// - One natural sub-module: cam_px_pack. It is combinational and does the byte0/byte1 → RGB111 reduction.
// - Everything else is a single FSM plus the col, row and base counters, kept in this file.
// TESTING
// - Reset, then drive vsync 1→0 with en=1 and send line 0 as bytes 0x0F,0xFF ×160.
//   → 160 writes, addr 0..159, data 3'b111, each px_wr one clk wide.
// - Bytes 0x08,0x80 then 0x00,0x08 at row 5, col 0.
//   → writes: addr 800 data 3'b110, then addr 801 data 3'b001.
// - Send a full 120 lines × 320 bytes, then vsync rising.
//   → last write at addr 19199; frame_done pulses once; 19200 total writes.
// - A line of 321 bytes, then a line of 330 bytes (165 pixels).
//   → line_err one pulse each; no write beyond col 159; no write from the dangling byte.
// - en=0 at the vsync fall, then a full frame.
//   → zero writes and no frame_done. Setting en=1 mid-frame still gives no writes until the next frame.
// - Assert rst mid-line at col 40, release, then run a full frame.
//   → outputs are 0 immediately; the next frame starts at addr 0 and completes normally.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture path: FSM encoding, default
// buffer geometry and the RGB444 bit positions kept in the RGB111 reduction.
package cam_pkg;

  localparam int CAM_X_DEF = 160;
  localparam int CAM_Y_DEF = 120;

  localparam logic [2:0] S_VBLANK    = 3'd0;
  localparam logic [2:0] S_SKIP      = 3'd1;
  localparam logic [2:0] S_LINE_IDLE = 3'd2;
  localparam logic [2:0] S_BYTE0     = 3'd3;
  localparam logic [2:0] S_BYTE1     = 3'd4;

  // MSB of each 4-bit channel: R in byte0[3:0], G in byte1[7:4], B in byte1[3:0]
  localparam int R_BIT = 3;
  localparam int G_BIT = 7;
  localparam int B_BIT = 3;

endpackage

// File: rtl/cam_px_pack.sv
// Combinational RGB444 byte pair to RGB111 {R,G,B} reduction.
module cam_px_pack
  import cam_pkg::*;
(
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  output logic [2:0] px
);

  logic unused_bits;

  assign px          = {byte0[R_BIT], byte1[G_BIT], byte1[B_BIT]};
  assign unused_bits = ^{byte0, byte1};

endmodule

// File: rtl/cam_capture_rgb111.sv
// Camera capture stage: pairs OV7670 bytes into RGB111 pixels and writes them
// linearly into the frame buffer, flagging completed frames and malformed lines.
module cam_capture_rgb111
  import cam_pkg::*;
#(
  parameter int CAM_SCREEN_X = CAM_X_DEF,
  parameter int CAM_SCREEN_Y = CAM_Y_DEF,
  parameter int AW           = 15,
  parameter int DW           = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    data,
  input  logic          vsync,
  input  logic          href,
  input  logic          en,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          line_err
);

  localparam logic [7:0]    COL_END   = 8'(CAM_SCREEN_X);
  localparam logic [7:0]    ROW_END   = 8'(CAM_SCREEN_Y);
  localparam logic [AW-1:0] LINE_STEP = AW'(CAM_SCREEN_X);

  logic [2:0]    state;
  logic          vsync_p0;
  logic [7:0]    byte0_p0;
  logic [7:0]    col;
  logic [7:0]    row;
  logic [AW-1:0] base;
  logic          frame_act;
  logic          err_seen;

  logic          vs_rise;
  logic          vs_fall;
  logic          row_live;
  logic          col_live;
  logic          capturing;
  logic          eol;
  logic [2:0]    px_p0;

  cam_px_pack u_px_pack (
    .byte0 (byte0_p0),
    .byte1 (data),
    .px    (px_p0)
  );

  assign vs_rise   = vsync & ~vsync_p0;
  assign vs_fall   = ~vsync & vsync_p0;
  assign row_live  = (row < ROW_END);
  assign col_live  = (col < COL_END);
  assign capturing = (state == S_LINE_IDLE) || (state == S_BYTE0) || (state == S_BYTE1);

  // href dropping after a complete or dangling pixel closes the line
  always_comb begin
    eol = 1'b0;
    if (capturing && !vs_rise && !href && (state == S_BYTE0 || state == S_BYTE1))
      eol = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_VBLANK;
      vsync_p0    <= 1'b0;
      byte0_p0    <= '0;
      col         <= '0;
      row         <= '0;
      base        <= '0;
      frame_act   <= 1'b0;
      err_seen    <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr       <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      vsync_p0   <= vsync;
      px_wr      <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;

      case (state)
        S_VBLANK: begin
          col       <= '0;
          row       <= '0;
          base      <= '0;
          err_seen  <= 1'b0;
          frame_act <= 1'b0;
          if (vs_fall) begin
            frame_act <= en;
            state     <= en ? S_LINE_IDLE : S_SKIP;
          end
        end

        S_SKIP: begin
          if (vs_rise)
            state <= S_VBLANK;
        end

        S_LINE_IDLE, S_BYTE0: begin
          if (vs_rise) begin
            frame_done <= frame_act && !row_live;
            state      <= S_VBLANK;
          end else if (href) begin
            byte0_p0 <= data;
            state    <= S_BYTE1;
          end else if (state == S_BYTE0) begin
            state <= S_LINE_IDLE;
          end
        end

        S_BYTE1: begin
          if (vs_rise) begin
            frame_done <= frame_act && !row_live;
            state      <= S_VBLANK;
          end else if (href) begin
            if (row_live && col_live) begin
              px_wr       <= 1'b1;
              mem_px_addr <= base + AW'(col);
              mem_px_data <= DW'(px_p0);
              col         <= col + 8'd1;
            end else if (row_live && !err_seen) begin
              line_err <= 1'b1;
              err_seen <= 1'b1;
            end
            state <= S_BYTE0;
          end else begin
            if (row_live && !err_seen)
              line_err <= 1'b1;
            state <= S_LINE_IDLE;
          end
        end

        default: state <= S_VBLANK;
      endcase

      // Row base advances by one line; it stops at the frame end so it never leaves AW
      if (eol) begin
        col      <= '0;
        err_seen <= 1'b0;
        if (row_live) begin
          row  <= row + 8'd1;
          base <= base + LINE_STEP;
        end
      end
    end
  end

endmodule
